// File: rtl/jtexterm_pkg.sv
// Shared types and PC-port bit positions for the MCU comm-RAM responder.
package jtexterm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam int PC_RDN   = 2;
  localparam int PC_WRN   = 3;
  localparam int PC_IRQ   = 4;
  localparam int PC_BUSEN = 5;

endpackage

// File: rtl/jtexterm_mcu_sync.sv
// 2-FF synchroniser for the MCU strobes plus a per-bit edge detector.
// RISE selects rising-edge detection per bit; other bits report falling edges.
module jtexterm_mcu_sync #(
  parameter logic [2:0] RISE = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q,
  output logic [2:0] edges
);

  logic [2:0] s1;
  logic [2:0] hist;

  // Reset to 1 so an idle (high) strobe never looks like an edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '1;
      q    <= '1;
      hist <= '1;
    end else begin
      s1   <= d;
      q    <= s1;
      hist <= q;
    end
  end

  assign edges = (RISE & q & ~hist) | (~RISE & ~q & hist);

endmodule

// File: rtl/jtexterm_mcu_comm.sv
// MCU-side responder: turns port-driven MCU bus cycles into single-cycle
// accesses on comm RAM port 1, and raises/holds the main CPU interrupt.
module jtexterm_mcu_comm
  import jtexterm_pkg::*;
#(
  parameter int AW    = 10,
  parameter int RDLAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    mcu_pa_out,
  input  logic [7:0]    mcu_pb_out,
  input  logic [7:0]    mcu_pc_out,
  output logic [7:0]    mcu_pa_in,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_q,
  input  logic          irq_ack,
  output logic          main_int_n,
  output logic          busy
);

  state_t     state;
  logic [1:0] cnt;
  logic [2:0] lvl;
  logic [2:0] edges;
  logic       rd_fall;
  logic       wr_fall;
  logic       irq_rise;
  logic       bus_en;
  logic       strobes_idle;
  logic       unused_bits;

  jtexterm_mcu_sync #(.RISE(3'b100)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     ({mcu_pc_out[PC_IRQ], mcu_pc_out[PC_WRN], mcu_pc_out[PC_RDN]}),
    .q     (lvl),
    .edges (edges)
  );

  assign rd_fall      = edges[0];
  assign wr_fall      = edges[1];
  assign irq_rise     = edges[2];
  assign bus_en       = mcu_pc_out[PC_BUSEN];
  assign strobes_idle = lvl[0] & lvl[1];
  assign unused_bits  = ^{mcu_pc_out[7:6], lvl[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      mcu_pa_in <= 8'hff;
      busy      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A write edge takes priority; a coincident read edge is dropped
          if (bus_en && (wr_fall || rd_fall)) begin
            ram_addr <= {mcu_pc_out[AW-9:0], mcu_pb_out};
            busy     <= 1'b1;
            cnt      <= '0;
            if (wr_fall) begin
              ram_din <= mcu_pa_out;
              ram_we  <= 1'b1;
              state   <= ST_WR;
            end else begin
              state   <= ST_RD_WAIT;
            end
          end
        end
        ST_WR: state <= ST_HOLD;
        ST_RD_WAIT: begin
          if (cnt == 2'(RDLAT - 1)) state <= ST_RD_CAP;
          else                      cnt   <= cnt + 2'd1;
        end
        ST_RD_CAP: begin
          mcu_pa_in <= ram_q;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (strobes_idle) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A new request in the same cycle as an ack keeps the interrupt asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           main_int_n <= 1'b1;
    else if (irq_rise) main_int_n <= 1'b0;
    else if (irq_ack)  main_int_n <= 1'b1;
  end

endmodule
